vga_timing_decoder: RTL

//  Receive end of the VGA timing interface. Samples the hsync/vsync/blank_n/RGB stream that vga

---
 rtl/vga_timing_decoder_if.sv | 12 +
 rtl/vga_timing_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder_if.sv
// VGA timing stream as presented to the DAC: pixel strobe, active-low syncs,
// active-video flag and 24-bit RGB. The source drives master, the monitor listens on slave.
interface vga_timing_decoder_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [23:0] rgb;

  modport master (output pix_en, hsync, vsync, blank_n, rgb);
  modport slave  (input  pix_en, hsync, vsync, blank_n, rgb);
endinterface

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing monitor: relocks to the sync stream, rebuilds pixel coordinates and
// flags line/frame/blank errors. Optional per-frame RGB CRC-16 is enabled by VGA_DEC_CRC_EN.
module vga_timing_decoder #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  vga_timing_decoder_if.slave         vid,
  input  logic                        err_clr,
  output logic [9:0]                  x_pos,
  output logic [9:0]                  y_pos,
  output logic                        pixel_valid,
  output logic                        frame_start,
  output logic                        locked,
  output logic [2:0]                  err_flags,
  output logic [15:0]                 frame_crc,
  output logic                        crc_valid
);

  localparam logic [1:0]  ST_SEARCH  = 2'd0;
  localparam logic [1:0]  ST_MEASURE = 2'd1;
  localparam logic [1:0]  ST_LOCKED  = 2'd2;
  localparam logic [10:0] H_TOTAL_C  = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP);
  localparam logic [10:0] H_START_C  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_C    = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_C  = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam logic [9:0]  V_START_C  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END_C    = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);
  localparam logic [10:0] H_SAT_C    = 11'h7FF;

  logic [1:0]  state_r, state_nxt_s;
  logic [10:0] h_cnt_r, h_nxt_s;
  logic [9:0]  v_cnt_r, v_nxt_s;
  logic [3:0]  good_cnt_r, good_nxt_s;
  logic        hs_prev_r, vs_prev_r, first_line_r, first_nxt_s, frame_bad_r;
  logic        hs_fall_s, vs_fall_s, line_err_s, frame_err_s, timeout_s;
  logic        active_s, frame_good_s, pv_s, tracking_s;
  logic [2:0]  err_set_s, err_r;
  logic [9:0]  x_pos_r, y_pos_r;
  logic        pixel_valid_r, frame_start_r, locked_r;

  // Edge detection, counter next values, error conditions and lock FSM next state
  always_comb begin
    hs_fall_s    = vid.pix_en & hs_prev_r & ~vid.hsync;
    vs_fall_s    = vid.pix_en & vs_prev_r & ~vid.vsync;
    h_nxt_s      = h_cnt_r;
    v_nxt_s      = v_cnt_r;
    state_nxt_s  = state_r;
    good_nxt_s   = good_cnt_r;
    first_nxt_s  = first_line_r;
    if (hs_fall_s) begin
      h_nxt_s = 11'd0;
    end else if (h_cnt_r == H_SAT_C) begin
      h_nxt_s = H_SAT_C;
    end else begin
      h_nxt_s = h_cnt_r + 11'd1;
    end
    if (vs_fall_s) begin
      v_nxt_s = 10'd0;
    end else if (hs_fall_s) begin
      v_nxt_s = v_cnt_r + 10'd1;
    end else begin
      v_nxt_s = v_cnt_r;
    end
    line_err_s   = hs_fall_s & ~first_line_r & ((h_cnt_r + 11'd1) != H_TOTAL_C);
    timeout_s    = vid.pix_en & ~hs_fall_s & (h_cnt_r == 11'd2046);
    frame_err_s  = vs_fall_s & ((v_cnt_r + 10'd1) != V_TOTAL_C);
    frame_good_s = ~frame_bad_r & ~line_err_s & ~frame_err_s;
    active_s     = (h_nxt_s >= H_START_C) && (h_nxt_s < H_END_C) &&
                   (v_nxt_s >= V_START_C) && (v_nxt_s < V_END_C);
    tracking_s   = (state_r != ST_SEARCH);

    case (state_r)
      ST_SEARCH: begin
        if (vs_fall_s && !timeout_s) begin
          state_nxt_s = ST_MEASURE;
          good_nxt_s  = 4'd0;
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (timeout_s) begin
          state_nxt_s = ST_SEARCH;
        end else if (vs_fall_s && frame_good_s) begin
          good_nxt_s = good_cnt_r + 4'd1;
          if ((good_cnt_r + 4'd1) >= LOCK_C) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_MEASURE;
          end
        end else if (vs_fall_s) begin
          good_nxt_s = 4'd0;
        end else begin
          state_nxt_s = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (line_err_s || frame_err_s || timeout_s) begin
          state_nxt_s = ST_SEARCH;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_SEARCH;
      end
    endcase

    // Line-period check is skipped for the first hsync fall after (re)entering SEARCH
    if (tracking_s && (state_nxt_s == ST_SEARCH)) begin
      first_nxt_s = 1'b1;
    end else if (hs_fall_s) begin
      first_nxt_s = 1'b0;
    end else begin
      first_nxt_s = first_line_r;
    end

    pv_s         = (state_nxt_s == ST_LOCKED) & active_s;
    err_set_s[0] = tracking_s & (line_err_s | timeout_s);
    err_set_s[1] = tracking_s & frame_err_s;
    err_set_s[2] = (state_r == ST_LOCKED) & vid.pix_en & (vid.blank_n != active_s);
  end

  // Timing state, coordinates and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_SEARCH;
      h_cnt_r       <= 11'd0;
      v_cnt_r       <= 10'd0;
      good_cnt_r    <= 4'd0;
      hs_prev_r     <= 1'b1;
      vs_prev_r     <= 1'b1;
      first_line_r  <= 1'b1;
      frame_bad_r   <= 1'b0;
      err_r         <= 3'b000;
      x_pos_r       <= 10'd0;
      y_pos_r       <= 10'd0;
      pixel_valid_r <= 1'b0;
      frame_start_r <= 1'b0;
      locked_r      <= 1'b0;
    end else begin
      err_r <= (err_clr ? 3'b000 : err_r) | err_set_s;
      if (vid.pix_en) begin
        hs_prev_r     <= vid.hsync;
        vs_prev_r     <= vid.vsync;
        h_cnt_r       <= h_nxt_s;
        v_cnt_r       <= v_nxt_s;
        state_r       <= state_nxt_s;
        good_cnt_r    <= good_nxt_s;
        first_line_r  <= first_nxt_s;
        frame_bad_r   <= vs_fall_s ? 1'b0 : (frame_bad_r | line_err_s);
        locked_r      <= (state_nxt_s == ST_LOCKED);
        pixel_valid_r <= pv_s;
        x_pos_r       <= pv_s ? 10'(h_nxt_s - H_START_C) : 10'd0;
        y_pos_r       <= pv_s ? (v_nxt_s - V_START_C) : 10'd0;
        frame_start_r <= vs_fall_s & (state_r == ST_LOCKED);
      end else begin
        frame_start_r <= 1'b0;
      end
    end
  end

  assign x_pos       = x_pos_r;
  assign y_pos       = y_pos_r;
  assign pixel_valid = pixel_valid_r;
  assign frame_start = frame_start_r;
  assign locked      = locked_r;
  assign err_flags   = err_r;

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc_run_r, frame_crc_r;
  logic        crc_valid_r;

  function automatic logic [15:0] crc16_24(input logic [15:0] crc_in, input logic [23:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Running CRC over visible pixels, published at each locked frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_run_r   <= 16'hFFFF;
      frame_crc_r <= 16'h0000;
      crc_valid_r <= 1'b0;
    end else if (vid.pix_en) begin
      crc_valid_r <= vs_fall_s & (state_r == ST_LOCKED);
      if (vs_fall_s) begin
        if (state_r == ST_LOCKED) begin
          frame_crc_r <= crc_run_r;
        end
        crc_run_r <= 16'hFFFF;
      end else if (pv_s) begin
        crc_run_r <= crc16_24(crc_run_r, vid.rgb);
      end
    end else begin
      crc_valid_r <= 1'b0;
    end
  end

  assign frame_crc = frame_crc_r;
  assign crc_valid = crc_valid_r;
`else
  logic rgb_unused_s;
  assign rgb_unused_s = ^vid.rgb;
  assign frame_crc    = 16'h0000;
  assign crc_valid    = 1'b0;
`endif

endmodule
